// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: opcode constants, the fetch FSM
// state encoding and the canonical NOP word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection for the held instruction: jump target, taken beq, or
// sequential. Purely combinational so a pipelined variant can reuse it.
module next_pc_calc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [31:0]       instr,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] jump_target;
    logic              unused_opcode_bits;

    // Word offset, sign-extended and scaled by 4.
    assign branch_off  = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    assign jump_target = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};

    assign unused_opcode_bits = ^instr[31:26];

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time from instruction
// memory, holds it for the control unit and advances the PC on consume.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              instr_valid,
    output logic [31:0]       instr_count
);

    // Handshakes: a request is accepted on any cycle where imem_req and
    // imem_ready are both high; read data is taken only on an imem_rvalid
    // cycle in FETCH (with imem_ready) or WAIT. The held word is consumed on
    // any cycle where instr_valid is high and stall is low.

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic              load_instr;
    logic              consume;
    logic [ADDR_W-1:0] next_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        load_instr  = 1'b0;
        consume     = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (imem_rvalid) begin
                        load_instr = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    load_instr = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    consume    = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Low address bits are forced to zero so a misaligned RESET_PC can never
    // reach the memory bus; every later PC stays aligned by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= {RESET_PC[ADDR_W-1:2], 2'b00};
            instr       <= NOP_WORD;
            instr_count <= '0;
        end else begin
            if (load_instr) begin
                instr <= imem_rdata;
            end
            if (consume) begin
                pc          <= next_pc;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

    assign imem_addr = pc;
    assign pc_plus4  = pc + ADDR_W'(4);
    assign opcode    = opcode_of(instr);

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .next_pc  (next_pc)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized fetch/consume
// traffic checked against an arithmetic next-PC model and a word queue.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic [31:0] instr_count;

    // Second instance starting high in memory; it sees a memory that always
    // returns a j with both jump and branch asserted.
    logic        hi_imem_req;
    logic [31:0] hi_imem_addr;
    logic [31:0] hi_instr;
    logic [5:0]  hi_opcode;
    logic [31:0] hi_pc;
    logic [31:0] hi_pc_plus4;
    logic        hi_instr_valid;
    logic [31:0] hi_instr_count;

    int          errors;
    int          checks;
    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    logic [31:0] exp_instr;
    logic [31:0] exp_q[$];

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .instr       (instr),
        .opcode      (opcode),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .instr_count (instr_count)
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h4000_0000)) u_dut_hi (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (hi_imem_req),
        .imem_addr   (hi_imem_addr),
        .imem_ready  (1'b1),
        .imem_rvalid (1'b1),
        .imem_rdata  (32'h0800_0040),
        .stall       (1'b0),
        .branch      (1'b1),
        .zero        (1'b1),
        .jump        (1'b1),
        .instr       (hi_instr),
        .opcode      (hi_opcode),
        .pc          (hi_pc),
        .pc_plus4    (hi_pc_plus4),
        .instr_valid (hi_instr_valid),
        .instr_count (hi_instr_count)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference model: MIPS next-PC rules in plain arithmetic.
    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [31:0] w,
                                                input logic br, input logic zr, input logic jp);
        logic [31:0]        seq;
        logic signed [15:0] imm;
        seq = cur + 32'd4;
        imm = w[15:0];
        if (jp) return (seq & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
        if (br && zr) return seq + 32'(int'(imm) * 4);
        return seq;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Memory driver: answer the pending fetch after the given delays
    // (rv_dly==0 means data in the same cycle as ready).
    task automatic serve(input int rdy_dly, input int rv_dly, input logic [31:0] word);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            step;
            n++;
        end
        chk1("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, exp_pc);
        exp_q.push_back(word);
        for (int i = 0; i < rdy_dly; i++) begin
            imem_ready  = 1'b0;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            step;
            chk1("fetch_hold_req", imem_req, 1'b1);
            chk("fetch_hold_addr", imem_addr, exp_pc);
            chk("fetch_no_latch", instr, exp_instr);
        end
        imem_ready = 1'b1;
        if (rv_dly == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        step;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        if (rv_dly > 0) begin
            chk1("wait_req", imem_req, 1'b0);
            chk1("wait_valid", instr_valid, 1'b0);
            chk("wait_instr", instr, exp_instr);
            for (int i = 1; i < rv_dly; i++) begin
                imem_rdata = $urandom;
                step;
                chk1("wait_req", imem_req, 1'b0);
                chk("wait_instr", instr, exp_instr);
                chk("wait_pc", pc, exp_pc);
            end
            imem_rvalid = 1'b1;
            imem_rdata  = word;
            step;
            imem_rvalid = 1'b0;
        end
        exp_instr = exp_q.pop_front();
        chk1("hold_valid", instr_valid, 1'b1);
        chk("hold_instr", instr, exp_instr);
        chk("hold_opcode", 32'(opcode), 32'(exp_instr[31:26]));
        chk("hold_pc", pc, exp_pc);
        chk("hold_pc4", pc_plus4, exp_pc + 32'd4);
        chk1("hold_req", imem_req, 1'b0);
    endtask

    // Consumer driver: stall for a while (with stray control/memory noise),
    // then consume with the given branch/zero/jump.
    task automatic consume(input int stall_cyc, input logic br, input logic zr, input logic jp);
        logic [31:0] np;
        for (int i = 0; i < stall_cyc; i++) begin
            stall       = 1'b1;
            branch      = 1'($urandom_range(0, 1));
            zero        = 1'($urandom_range(0, 1));
            jump        = 1'($urandom_range(0, 1));
            imem_ready  = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            step;
            chk1("stall_valid", instr_valid, 1'b1);
            chk("stall_instr", instr, exp_instr);
            chk("stall_pc", pc, exp_pc);
            chk1("stall_req", imem_req, 1'b0);
            chk("stall_count", instr_count, exp_count);
        end
        stall       = 1'b0;
        branch      = br;
        zero        = zr;
        jump        = jp;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        np = ref_next_pc(exp_pc, exp_instr, br, zr, jp);
        step;
        branch    = 1'b0;
        zero      = 1'b0;
        jump      = 1'b0;
        exp_pc    = np;
        exp_count = exp_count + 32'd1;
        chk1("cons_valid", instr_valid, 1'b0);
        chk("cons_pc", pc, exp_pc);
        chk("cons_count", instr_count, exp_count);
        chk1("cons_req", imem_req, 1'b1);
        chk("cons_addr", imem_addr, exp_pc);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        stall       = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        jump        = 1'b0;
        exp_pc      = 32'h0;
        exp_count   = 32'h0;
        exp_instr   = 32'h0;

        // Reset values
        repeat (3) step;
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        chk("rst_instr", instr, 32'h0);
        chk("rst_opcode", 32'(opcode), 32'h0);
        chk("rst_count", instr_count, 32'h0);

        // Zero-latency first fetch: one dead cycle, then FETCH, then HOLD
        rst_n       = 1'b1;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2008_0005;
        chk1("idle_req", imem_req, 1'b0);
        step;
        chk1("t1_req", imem_req, 1'b1);
        chk("t1_addr", imem_addr, 32'h0);
        step;
        chk1("t1_valid", instr_valid, 1'b1);
        chk("t1_opcode", 32'(opcode), 32'h08);
        chk("t1_instr", instr, 32'h2008_0005);
        chk("t1_pc", pc, 32'h0);
        chk("t1_pc4", pc_plus4, 32'h4);
        chk("hi_opcode", 32'(hi_opcode), 32'h02);
        chk("hi_pc", hi_pc, 32'h4000_0000);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        step;
        chk("t1_cons_pc", pc, 32'h4);
        chk("t1_cons_count", instr_count, 32'h1);
        chk1("t1_cons_valid", instr_valid, 1'b0);
        chk("hi_jump_pc", hi_pc, 32'h4000_0100);
        chk("hi_count", hi_instr_count, 32'h1);
        exp_pc    = 32'h4;
        exp_count = 32'h1;
        exp_instr = 32'h2008_0005;

        // Slow memory at pc=8: ready after 2 cycles, data 3 cycles later
        serve(0, 0, 32'h3421_0001);
        consume(0, 1'b0, 1'b0, 1'b0);
        chk("pc_at_8", pc, 32'h8);
        serve(2, 3, 32'h8C22_0010);
        consume(0, 1'b0, 1'b0, 1'b0);
        serve(1, 1, 32'h0000_0020);
        consume(0, 1'b0, 1'b0, 1'b0);
        chk("pc_at_10", pc, 32'h10);

        // beq at 0x10 with offset -2, taken and not taken
        serve(0, 1, 32'h1000_FFFE);
        consume(0, 1'b1, 1'b1, 1'b0);
        chk("beq_taken", pc, 32'h0C);
        serve(1, 0, 32'hAC43_0004);
        consume(0, 1'b0, 1'b0, 1'b0);
        serve(0, 2, 32'h1000_FFFE);
        consume(0, 1'b1, 1'b0, 1'b0);
        chk("beq_not_taken", pc, 32'h14);

        // Five stall cycles, then exactly one consume
        serve(0, 0, $urandom);
        consume(5, 1'b0, 1'b0, 1'b0);
        step;
        chk("stall_once_count", instr_count, exp_count);
        chk1("stall_once_valid", instr_valid, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            consume($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset while in WAIT
        imem_ready = 1'b1;
        step;
        imem_ready = 1'b0;
        chk1("pre_rst_wait_req", imem_req, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("arst_req", imem_req, 1'b0);
        chk1("arst_valid", instr_valid, 1'b0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_opcode", 32'(opcode), 32'h0);
        chk("arst_count", instr_count, 32'h0);
        step;
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step;
        chk("late_rvalid_instr", instr, 32'h0);
        chk1("late_rvalid_req", imem_req, 1'b1);
        step;
        chk("late_rvalid_fetch_instr", instr, 32'h0);
        chk1("late_rvalid_still_fetch", imem_req, 1'b1);
        imem_rvalid = 1'b0;
        exp_pc    = 32'h0;
        exp_count = 32'h0;
        exp_instr = 32'h0;
        serve(0, 0, 32'h2008_0005);
        consume(1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_pc", pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
